// File: rtl/imem_loader_pkg.sv
// Shared state type and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word and pulses once when the word is complete.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        shift_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        wordValid_o
);

    logic [23:0] shift_q;
    logic [31:0] word_q;
    logic        wordValid_q;

    // Earlier bytes slide toward bit 0 so the first byte lands in [7:0] of the finished word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q     <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
        end else begin
            wordValid_q <= 1'b0;
            if (shift_i) begin
                if (last_i) begin
                    word_q      <= {byte_i, shift_q};
                    wordValid_q <= 1'b1;
                end else begin
                    shift_q <= {byte_i, shift_q[23:8]};
                end
            end
        end
    end

    assign word_o      = word_q;
    assign wordValid_o = wordValid_q;

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: header, data words and (with IMEM_LOADER_CHECKSUM_EN) a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_core_rst_n,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_e END_STATE = CSUM;
`else
    localparam loader_state_e END_STATE = DONE;
`endif

    loader_state_e               state_q, state_d;
    logic [1:0]                  byteCnt_q, byteCnt_d;
    logic [ADDR_W-1:0]           wordIdx_q, wordIdx_d;
    logic [7:0]                  nLo_q, nLo_d;
    logic [8*HDR_BYTES-1:0]      nWords_q, nWords_d;
    logic [8*HDR_BYTES-1:0]      hdrWords;
    logic                        rxReady_q, done_q, err_q, coreRstN_q;
    logic                        accept, packByte, packLast, lastWord, wordValid;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                  csum_q, csum_d;
`endif

    assign accept   = i_rx_valid && rxReady_q;
    assign packByte = accept && (state_q == DATA);
    assign packLast = packByte && (byteCnt_q == 2'(BYTES_PER_WORD - 1));
    assign lastWord = 32'(wordIdx_q) == (32'(nWords_q) - 32'd1);
    assign hdrWords = {i_rx_data, nLo_q};

    byte_packer u_packer (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .byte_i      (i_rx_data),
        .shift_i     (packByte),
        .last_i      (packLast),
        .word_o      (o_mem_wdata),
        .wordValid_o (wordValid)
    );

    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        wordIdx_d = wordIdx_q;
        nLo_d     = nLo_q;
        nWords_d  = nWords_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        // Word index advances on the write strobe so o_mem_addr matches the word being written.
        if (wordValid) begin
            wordIdx_d = wordIdx_q + ADDR_W'(1);
        end
        case (state_q)
            HDR_LO: begin
                if (accept) begin
                    nLo_d   = i_rx_data;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    nWords_d = hdrWords;
                    if (hdrWords == '0) begin
                        state_d = END_STATE;
                    end else if (32'(hdrWords) > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (packByte) begin
                    byteCnt_d = byteCnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ i_rx_data;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // Leave DATA as soon as the last byte lands so a checksum byte in the write cycle is not lost.
                if (packLast && lastWord) begin
                    state_d = CSUM;
                end
`else
                if (wordValid && lastWord) begin
                    state_d = DONE;
                end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_d = (i_rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= HDR_LO;
            byteCnt_q  <= '0;
            wordIdx_q  <= '0;
            nLo_q      <= '0;
            nWords_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            rxReady_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            coreRstN_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byteCnt_q  <= byteCnt_d;
            wordIdx_q  <= wordIdx_d;
            nLo_q      <= nLo_d;
            nWords_q   <= nWords_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            rxReady_q  <= (state_d != DONE) && (state_d != ERR);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
            coreRstN_q <= (state_d == DONE);
        end
    end

    assign o_rx_ready   = rxReady_q;
    assign o_mem_we     = wordValid;
    assign o_mem_addr   = wordIdx_q;
    assign o_core_rst_n = coreRstN_q;
    assign o_done       = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; also exercises the checksum path when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        rxData = 8'h00;
    logic              rxValid = 1'b0;
    logic              rxReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              coreRstN;
    logic              done;
    logic              err;

    int nAsserts = 0;
    int nFail    = 0;

    logic [31:0] wrAddrQ[$];
    logic [31:0] wrDataQ[$];

    logic [7:0] img3  [0:13] = '{8'h03, 8'h00,
                                 8'h44, 8'h33, 8'h22, 8'h11,
                                 8'h5A, 8'h5A, 8'hA5, 8'hA5,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int         gap3  [0:13] = '{0, 3, 1, 0, 5, 2, 0, 4, 1, 3, 0, 5, 2, 1};
    logic [31:0] exp3 [0:2]  = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rxData),
        .i_rx_valid   (rxValid),
        .o_rx_ready   (rxReady),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_wdata  (memWdata),
        .o_core_rst_n (coreRstN),
        .o_done       (done),
        .o_err        (err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Log every write strobe on the falling edge; a strobe wider than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            wrAddrQ.push_back(32'(memAddr));
            wrDataQ.push_back(memWdata);
        end
    end

    // Hard stop in case the directed sequence itself wedges.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Entered and left 1 ns after a rising edge; holds the byte until the loader takes it.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waitCnt;
        rxValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rxData  = b;
        rxValid = 1'b1;
        waitCnt = 0;
        while (rxReady !== 1'b1 && waitCnt < 20) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (waitCnt >= 20) begin
            checkOutput("rxReadyTimeout", {31'b0, rxReady}, 32'd1);
        end
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic doReset(input string tag);
        rxValid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_rstReady"}, {31'b0, rxReady}, 32'd0);
        checkOutput({tag, "_rstWe"}, {31'b0, memWe}, 32'd0);
        checkOutput({tag, "_rstAddr"}, 32'(memAddr), 32'd0);
        checkOutput({tag, "_rstWdata"}, memWdata, 32'd0);
        checkOutput({tag, "_rstCore"}, {31'b0, coreRstN}, 32'd0);
        checkOutput({tag, "_rstDoneErr"}, {30'b0, done, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_readyAfterRst"}, {31'b0, rxReady}, 32'd1);
    endtask

    // Closes an image: sends the checksum byte when that feature is built in, else just lets the last write retire.
    task automatic finishImage(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        applyStimulus(csum, 0);
`else
        if (csum !== 8'hxx) begin
            @(posedge clk);
            #1;
        end
`endif
    endtask

    initial begin
        int base;

        // Single word, back-to-back bytes.
        doReset("t1");
        base = wrAddrQ.size();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h78, 0);
        applyStimulus(8'h56, 0);
        applyStimulus(8'h34, 0);
        applyStimulus(8'h12, 0);
        checkOutput("t1_we", {31'b0, memWe}, 32'd1);
        checkOutput("t1_addr", 32'(memAddr), 32'd0);
        checkOutput("t1_wdata", memWdata, 32'h12345678);
        checkOutput("t1_coreHeld", {31'b0, coreRstN}, 32'd0);
        finishImage(8'h08);
        checkOutput("t1_done", {31'b0, done}, 32'd1);
        checkOutput("t1_coreRun", {31'b0, coreRstN}, 32'd1);
        checkOutput("t1_readyLow", {31'b0, rxReady}, 32'd0);
        checkOutput("t1_weLow", {31'b0, memWe}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1_doneHeld", {30'b0, done, err}, 32'd2);
        checkOutput("t1_writeCount", 32'(wrAddrQ.size() - base), 32'd1);

        // Three words with idle gaps between bytes.
        doReset("t2");
        base = wrAddrQ.size();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(img3[i], gap3[i]);
            if (i == 7) begin
                checkOutput("t2_midNotDone", {30'b0, done, err}, 32'd0);
            end
        end
        finishImage(8'h66);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2_writeCount", 32'(wrAddrQ.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (wrAddrQ.size() > base + i) begin
                checkOutput($sformatf("t2_addr%0d", i), wrAddrQ[base + i], 32'(i));
                checkOutput($sformatf("t2_data%0d", i), wrDataQ[base + i], exp3[i]);
            end
        end
        checkOutput("t2_done", {31'b0, done}, 32'd1);

        // Largest legal image size is accepted.
        doReset("t3");
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        checkOutput("t3_n256NoErr", {31'b0, err}, 32'd0);
        checkOutput("t3_n256Ready", {31'b0, rxReady}, 32'd1);

        // One word too many is rejected and stays rejected.
        doReset("t4");
        base = wrAddrQ.size();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h01, 0);
        checkOutput("t4_err", {31'b0, err}, 32'd1);
        checkOutput("t4_readyLow", {31'b0, rxReady}, 32'd0);
        checkOutput("t4_coreHeld", {31'b0, coreRstN}, 32'd0);
        checkOutput("t4_notDone", {31'b0, done}, 32'd0);
        rxData  = 8'hFF;
        rxValid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rxValid = 1'b0;
        checkOutput("t4_errSticky", {31'b0, err}, 32'd1);
        checkOutput("t4_noWrites", 32'(wrAddrQ.size() - base), 32'd0);

        // Reset in the middle of a word, then a fresh image.
        doReset("t5");
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        doReset("t5b");
        base = wrAddrQ.size();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h0D, 1);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'hFE, 2);
        applyStimulus(8'hCA, 0);
        finishImage(8'hC9);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_writeCount", 32'(wrAddrQ.size() - base), 32'd1);
        if (wrAddrQ.size() > base) begin
            checkOutput("t5_addr", wrAddrQ[base], 32'd0);
            checkOutput("t5_data", wrDataQ[base], 32'hCAFEF00D);
        end
        checkOutput("t5_done", {31'b0, done}, 32'd1);

        // Empty image.
        doReset("t6");
        base = wrAddrQ.size();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checkOutput("t6_csumWait", {30'b0, done, rxReady}, 32'd1);
        applyStimulus(8'h00, 0);
`endif
        checkOutput("t6_done", {31'b0, done}, 32'd1);
        checkOutput("t6_coreRun", {31'b0, coreRstN}, 32'd1);
        checkOutput("t6_noWrites", 32'(wrAddrQ.size() - base), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch on the same data.
        doReset("t7");
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        applyStimulus(8'hCC, 0);
        applyStimulus(8'hDD, 0);
        applyStimulus(8'h00, 0);
        checkOutput("t7_csumOk", {30'b0, done, err}, 32'd2);
        doReset("t8");
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        applyStimulus(8'hCC, 0);
        applyStimulus(8'hDD, 0);
        applyStimulus(8'h01, 0);
        checkOutput("t8_csumBad", {30'b0, done, err}, 32'd1);
        checkOutput("t8_coreHeld", {31'b0, coreRstN}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
